// File: rtl/button_event_decoder.sv
// button_event_decoder: classifies debounced presses as short, long or double-click, with auto-repeat during long holds
module button_event_decoder #(
  parameter int TICK_DIV = 100000,
  parameter int LONG_T   = 50,
  parameter int DOUBLE_T = 25,
  parameter int REPEAT_T = 10
) (
  input  logic clk_core,
  input  logic rst_core,
  input  logic button_i,
  output logic short_o,
  output logic long_o,
  output logic double_o,
  output logic repeat_o,
  output logic held_o
);
  localparam int MAX_LD = LONG_T > DOUBLE_T ? LONG_T : DOUBLE_T;
  localparam int MAX_T = MAX_LD > REPEAT_T ? MAX_LD : REPEAT_T;
  localparam int TW = $clog2(MAX_T) + 1;
  localparam int PW = $clog2(TICK_DIV) + 1;
  localparam logic [2:0] IDLE           = 3'd0;
  localparam logic [2:0] PRESSED        = 3'd1;
  localparam logic [2:0] LONG_HELD      = 3'd2;
  localparam logic [2:0] WAIT_SECOND    = 3'd3;
  localparam logic [2:0] SECOND_PRESSED = 3'd4;
  // thresholds fire on the tick that would carry the timer onto the limit
  localparam logic [TW-1:0] LONG_END   = TW'(LONG_T - 1);
  localparam logic [TW-1:0] DOUBLE_END = TW'(DOUBLE_T - 1);
  localparam logic [TW-1:0] REPEAT_END = TW'(REPEAT_T - 1);
  localparam logic [PW-1:0] PRE_END    = PW'(TICK_DIV - 1);
  logic [2:0] state, state_n;
  logic [TW-1:0] timer;
  logic [PW-1:0] pre;
  logic prev_btn, rise, tick, sh, lg, db, rp;
  assign rise = button_i & ~prev_btn;
  assign tick = pre == PRE_END;
  always_comb begin
    state_n = state;
    sh = 1'b0;
    lg = 1'b0;
    db = 1'b0;
    rp = 1'b0;
    case (state)
      IDLE: state_n = rise ? PRESSED : IDLE;
      PRESSED: begin
        lg = button_i && tick && timer == LONG_END;
        state_n = !button_i ? WAIT_SECOND : lg ? LONG_HELD : PRESSED;
      end
      LONG_HELD: begin
        rp = button_i && REPEAT_T > 0 && tick && timer == REPEAT_END;
        state_n = button_i ? LONG_HELD : IDLE;
      end
      WAIT_SECOND: begin
        // expiry outranks a coincident rise; that rise opens a fresh sequence
        sh = tick && timer == DOUBLE_END;
        db = !sh && rise;
        state_n = sh ? (rise ? PRESSED : IDLE) : db ? SECOND_PRESSED : WAIT_SECOND;
      end
      SECOND_PRESSED: state_n = button_i ? SECOND_PRESSED : IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state <= IDLE;
      timer <= '0;
      pre <= '0;
      prev_btn <= 1'b1;
      short_o <= 1'b0;
      long_o <= 1'b0;
      double_o <= 1'b0;
      repeat_o <= 1'b0;
      held_o <= 1'b0;
    end else begin
      prev_btn <= button_i;
      pre <= tick ? '0 : pre + 1'b1;
      state <= state_n;
      timer <= (state_n != state || rp) ? '0 : timer + TW'(tick);
      short_o <= sh;
      long_o <= lg;
      double_o <= db;
      repeat_o <= rp;
      held_o <= state_n == PRESSED || state_n == LONG_HELD || state_n == SECOND_PRESSED;
    end
  end
endmodule

// File: tb/tb_button_event_decoder.sv
// tb_button_event_decoder: directed scenario table, reset/prescaler corner cases and random stimulus against a timestamp model
module tb_button_event_decoder;
  localparam int LONG_T = 20, DOUBLE_T = 10, REPEAT_T = 5;
  logic clk, rst, button, button4;
  logic short_o, long_o, double_o, repeat_o, held_o;
  logic short4, long4, double4, repeat4, held4;
  int total, passed, cyc, p0, first, n_s, n_l, n_d, n_r;
  typedef enum {P_IDLE, P_DOWN, P_LONG, P_GAP, P_SECOND} phase_t;
  phase_t ph;
  int e;
  logic m_pb, es, el, ed, er, eh;
  typedef struct {int h1; int g; int h2; int s; int l; int d; int r; int first;} vec_t;
  vec_t tbl[8];

  button_event_decoder #(.TICK_DIV(1), .LONG_T(LONG_T), .DOUBLE_T(DOUBLE_T), .REPEAT_T(REPEAT_T)) dut (
    .clk_core(clk), .rst_core(rst), .button_i(button), .short_o(short_o), .long_o(long_o),
    .double_o(double_o), .repeat_o(repeat_o), .held_o(held_o));
  button_event_decoder #(.TICK_DIV(4), .LONG_T(LONG_T), .DOUBLE_T(DOUBLE_T), .REPEAT_T(REPEAT_T)) dut4 (
    .clk_core(clk), .rst_core(rst), .button_i(button4), .short_o(short4), .long_o(long4),
    .double_o(double4), .repeat_o(repeat4), .held_o(held4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: each phase remembers the edge it was entered on; thresholds are elapsed-edge counts
  initial begin
    cyc = 0; ph = P_IDLE; e = 0; m_pb = 1'b1;
    {es, el, ed, er, eh} = '0;
    forever begin
      logic rise;
      int t;
      @(posedge clk);
      cyc++;
      {es, el, ed, er} = '0;
      if (rst) begin
        ph = P_IDLE; m_pb = 1'b1; eh = 1'b0;
      end else begin
        rise = button && !m_pb;
        m_pb = button;
        t = cyc - e;
        case (ph)
          P_IDLE: if (rise) begin ph = P_DOWN; e = cyc; end
          P_DOWN:
            if (!button) begin ph = P_GAP; e = cyc; end
            else if (t == LONG_T) begin el = 1'b1; ph = P_LONG; e = cyc; end
          P_LONG:
            if (!button) ph = P_IDLE;
            else if (REPEAT_T > 0 && t == REPEAT_T) begin er = 1'b1; e = cyc; end
          P_GAP:
            if (t == DOUBLE_T) begin
              es = 1'b1;
              if (rise) begin ph = P_DOWN; e = cyc; end else ph = P_IDLE;
            end else if (rise) begin ed = 1'b1; ph = P_SECOND; e = cyc; end
          P_SECOND: if (!button) ph = P_IDLE;
          default: ph = P_IDLE;
        endcase
        eh = ph == P_DOWN || ph == P_LONG || ph == P_SECOND;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
    else passed++;
  endtask

  task automatic observe();
    chk("short", int'(short_o), int'(es));
    chk("long", int'(long_o), int'(el));
    chk("double", int'(double_o), int'(ed));
    chk("repeat", int'(repeat_o), int'(er));
    chk("held", int'(held_o), int'(eh));
    n_s += int'(short_o); n_l += int'(long_o); n_d += int'(double_o); n_r += int'(repeat_o);
    if (first < 0 && (short_o || long_o || double_o)) first = cyc - p0;
  endtask

  task automatic cyc1(input logic b);
    @(negedge clk);
    observe();
    button = b;
  endtask

  task automatic clr();
    n_s = 0; n_l = 0; n_d = 0; n_r = 0; first = -1;
  endtask

  task automatic run_seq(input int h1, input int g, input int h2);
    clr();
    @(negedge clk);
    observe();
    button = 1'b1;
    p0 = cyc + 1;
    repeat (h1 - 1) cyc1(1'b1);
    repeat (g) cyc1(1'b0);
    repeat (h2) cyc1(1'b1);
    repeat (45) cyc1(1'b0);
  endtask

  initial begin
    total = 0; passed = 0; p0 = 0;
    clr();
    tbl[0] = '{5, 0, 0, 1, 0, 0, 0, 15};
    tbl[1] = '{5, 4, 5, 0, 0, 1, 0, 9};
    tbl[2] = '{32, 0, 0, 0, 1, 0, 2, 20};
    tbl[3] = '{5, 10, 25, 1, 1, 0, 0, 15};
    tbl[4] = '{5, 9, 5, 0, 0, 1, 0, 14};
    tbl[5] = '{20, 0, 0, 1, 0, 0, 0, 30};
    tbl[6] = '{21, 0, 0, 0, 1, 0, 0, 20};
    tbl[7] = '{5, 4, 40, 0, 0, 1, 0, 9};
    rst = 1'b1; button = 1'b0; button4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_short", int'(short_o), 0);
    chk("rst_long", int'(long_o), 0);
    chk("rst_double", int'(double_o), 0);
    chk("rst_repeat", int'(repeat_o), 0);
    chk("rst_held", int'(held_o), 0);
    rst = 1'b0;
    repeat (5) cyc1(1'b0);
    for (int i = 0; i < 8; i++) begin
      run_seq(tbl[i].h1, tbl[i].g, tbl[i].h2);
      chk($sformatf("vec%0d_short_cnt", i), n_s, tbl[i].s);
      chk($sformatf("vec%0d_long_cnt", i), n_l, tbl[i].l);
      chk($sformatf("vec%0d_double_cnt", i), n_d, tbl[i].d);
      chk($sformatf("vec%0d_repeat_cnt", i), n_r, tbl[i].r);
      chk($sformatf("vec%0d_first_at", i), first, tbl[i].first);
    end
    // reset in the middle of a long hold, button kept down through and after it
    clr();
    @(negedge clk);
    observe();
    button = 1'b1;
    p0 = cyc + 1;
    repeat (22) cyc1(1'b1);
    chk("rst_hold_long_before", n_l, 1);
    @(negedge clk);
    observe();
    rst = 1'b1;
    repeat (2) cyc1(1'b1);
    rst = 1'b0;
    clr();
    repeat (30) cyc1(1'b1);
    chk("rst_hold_long_after", n_l, 0);
    chk("rst_hold_repeat_after", n_r, 0);
    chk("rst_hold_held", int'(held_o), 0);
    repeat (5) cyc1(1'b0);
    run_seq(21, 0, 0);
    chk("fresh_press_long", n_l, 1);
    // prescaled instance: first tick lands anywhere in the first four cycles
    begin
      int t4, held_bad, l4, sd4;
      t4 = -1; held_bad = 0; l4 = 0; sd4 = 0;
      @(negedge clk);
      observe();
      button4 = 1'b1;
      p0 = cyc + 1;
      for (int i = 1; i <= 120; i++) begin
        int k;
        @(negedge clk);
        observe();
        k = cyc - p0;
        if (k >= 0 && k <= 99 && !held4) held_bad++;
        if (long4 && t4 < 0) t4 = k;
        l4 += int'(long4);
        sd4 += int'(short4) + int'(double4);
        button4 = i < 100;
      end
      chk("div4_long_lo", int'(t4 >= 77), 1);
      chk("div4_long_hi", int'(t4 <= 80), 1);
      chk("div4_long_cnt", l4, 1);
      chk("div4_other_cnt", sd4, 0);
      chk("div4_held_gaps", held_bad, 0);
      chk("div4_held_after", int'(held4), 0);
    end
    begin
      int run;
      logic lvl;
      run = 0; lvl = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        observe();
        if (run == 0) begin lvl = ~lvl; run = $urandom_range(1, 25); end
        run--;
        button = lvl;
        rst = $urandom_range(0, 499) == 0;
      end
      rst = 1'b0;
      repeat (3) cyc1(1'b0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
